accum_addsub_seq: RTL and testbench
===================================

ACCUM_ADDSUB_SEQ -- requirements
Module: accum_addsub_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 4, accumulator and operand width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  command present.
REQ-005 SHALL have port: in_ready  output  1  command accepted when in_valid & in_ready.
REQ-006 SHALL have port: in_op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-007 SHALL have port: in_data  input  WIDTH  operand.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  result consumed when out_valid & out_ready.
REQ-010 SHALL have port: out_acc  output  WIDTH  accumulator value after the command.
REQ-011 SHALL have port: out_cout  output  1  adder carry-out; for SUB, 1 = no borrow.
REQ-012 SHALL have port: out_ovfl  output  1  two's-complement overflow of this command.
REQ-013 SHALL have port: sticky_ovfl  output  1  OR of all out_ovfl since last CLEAR/reset.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; in_ready = 1 only in IDLE.
REQ-015 SHALL capture in_op and in_data on handshake in IDLE and move to EXEC.
REQ-016 SHALL, in EXEC, compute and register acc result, out_cout and out_ovfl, then move to RESP.
REQ-017 SHALL assert out_valid only in RESP; leave RESP for IDLE on out_ready, else hold all outputs stable.
REQ-018 SHALL give latency: handshake in cycle N -> out_valid high in cycle N+2; max throughput one command per 3 cycles.
REQ-019 SHALL compute ADD as acc + data and SUB as acc + ~data + 1 (invert-and-carry-in), modulo 2^WIDTH.
REQ-020 SHALL set out_ovfl = carry into MSB XOR carry out of MSB for ADD/SUB.
REQ-021 SHALL, for LOAD, set acc = data, out_cout = 0, out_ovfl = 0.
REQ-022 SHALL, for CLEAR, set acc = 0, out_cout = 0, out_ovfl = 0, sticky_ovfl = 0.
REQ-023 SHALL set sticky_ovfl in EXEC whenever out_ovfl becomes 1; the clearing by CLEAR takes effect in the same EXEC cycle.
REQ-024 SHALL ignore in_valid outside IDLE; an in_valid held high across RESP is accepted in the first following IDLE cycle.
REQ-025 SHALL wrap the result silently on overflow when saturation is not compiled in.

Reset
REQ-026 SHALL, on rst, set state IDLE, acc 0, out_acc 0, out_cout 0, out_ovfl 0, sticky_ovfl 0, out_valid 0; in_ready becomes 1 the cycle after rst deasserts.
REQ-027 SHALL give rst priority over any handshake in the same cycle; a command in EXEC or RESP is discarded without updating acc.

Configuration
REQ-028 SHALL compile saturation in only when macro ACCUM_ADDSUB_SAT_EN is defined.
REQ-029 SHALL, with ACCUM_ADDSUB_SAT_EN, clamp an overflowing ADD/SUB to max positive (0111 for WIDTH 4) when the operands are positive, or to min negative (1000) when they are negative; out_ovfl and sticky still assert.
REQ-030 SHALL, without ACCUM_ADDSUB_SAT_EN, produce the wrapped sum (REQ-025) and contain no saturation logic.

Structure
REQ-031 SHALL define op encodings (OP_ADD/OP_SUB/OP_LOAD/OP_CLEAR) and FSM state encodings in shared package accum_addsub_pkg.
REQ-032 SHALL place the combinational ripple add/subtract (operand XOR with dir, carry chain, MSB carry-in tap) in one sub-module addsub_core.

Verification
REQ-033 SHALL check: rst held 2 cycles -> out_acc 0000, sticky 0, out_valid 0, in_ready 1 after release.
REQ-034 SHALL check: LOAD 0101, then ADD 0011 -> out_acc 1000, cout 0, ovfl 1, sticky 1; with ACCUM_ADDSUB_SAT_EN -> out_acc 0111.
REQ-035 SHALL check: LOAD 0011, then SUB 0101 -> out_acc 1110, cout 0, ovfl 0; LOAD 0001, then ADD 1111 -> 0000, cout 1, ovfl 0.
REQ-036 SHALL check: out_ready low for 3 cycles in RESP -> out_valid and out_acc held, in_ready 0; ready high -> IDLE next cycle.
REQ-037 SHALL check: rst asserted during EXEC of ADD 0010 after LOAD 0100 -> acc 0000 after reset, no out_valid.
REQ-038 SHALL check: CLEAR after an overflow -> sticky_ovfl 0 and out_acc 0000 at out_valid, two cycles after handshake.

Source files
------------

// File: rtl/accum_addsub_pkg.sv
// Shared op and FSM state encodings for the add/sub accumulator.
// Saturation is compiled in by defining ACCUM_ADDSUB_SAT_EN.
package accum_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/accum_addsub_seq_addsub_core.sv
// Combinational ripple adder/subtractor with carry-out and overflow.
// Subtraction inverts b and feeds sub in as the LSB carry.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;

    always_comb begin
        bx   = b ^ {WIDTH{sub}};
        c    = '0;
        sum  = '0;
        c[0] = sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout = c[WIDTH];
    // carry into the MSB disagreeing with carry out flags signed overflow
    assign ovfl = c[WIDTH-1] ^ c[WIDTH];

endmodule

// File: rtl/accum_addsub_seq.sv
// Three-state sequential accumulator: ADD/SUB/LOAD/CLEAR commands.
// Define ACCUM_ADDSUB_SAT_EN to clamp overflowing ADD/SUB results.
module accum_addsub_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             out_ovfl,
    output logic             sticky_ovfl
);

    import accum_addsub_pkg::*;

    state_e           state;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovfl;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (acc),
        .b    (cmd_data),
        .sub  (cmd_op == OP_SUB),
        .sum  (sum),
        .cout (cout),
        .ovfl (ovfl)
    );

`ifdef ACCUM_ADDSUB_SAT_EN
    // on overflow both effective operands share acc's sign
    always_comb begin
        res = sum;
        if (ovfl) begin
            res = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res = sum;
`endif

    assign out_acc = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            acc         <= '0;
            out_cout    <= 1'b0;
            out_ovfl    <= 1'b0;
            sticky_ovfl <= 1'b0;
            cmd_op      <= OP_ADD;
            cmd_data    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cmd_op   <= op_e'(in_op);
                        cmd_data <= in_data;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    out_valid <= 1'b1;
                    unique case (cmd_op)
                        OP_ADD, OP_SUB: begin
                            acc      <= res;
                            out_cout <= cout;
                            out_ovfl <= ovfl;
                            if (ovfl) sticky_ovfl <= 1'b1;
                        end
                        OP_LOAD: begin
                            acc      <= cmd_data;
                            out_cout <= 1'b0;
                            out_ovfl <= 1'b0;
                        end
                        OP_CLEAR: begin
                            acc         <= '0;
                            out_cout    <= 1'b0;
                            out_ovfl    <= 1'b0;
                            sticky_ovfl <= 1'b0;
                        end
                    endcase
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_addsub_seq.sv
// Directed plus randomized bench for accum_addsub_seq.
// Expected results come from a signed/unsigned arithmetic model.
module tb_accum_addsub_seq;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_acc;
    logic         out_cout;
    logic         out_ovfl;
    logic         sticky_ovfl;

    int tests = 0;
    int fails = 0;
    int macc = 0;
    int msticky = 0;
    int e_acc, e_cout, e_ovfl;

    always #5 clk = ~clk;

    accum_addsub_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_cout    (out_cout),
        .out_ovfl    (out_ovfl),
        .sticky_ovfl (sticky_ovfl)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > SMAX) ? v - (1 << W) : v;
    endfunction

    task automatic model(input int op, input int d);
        int full, ss;
        full = 0;
        ss = 0;
        e_cout = 0;
        e_ovfl = 0;
        case (op)
            0, 1: begin
                if (op == 0) begin
                    full = macc + d;
                    ss   = sgn(macc) + sgn(d);
                end else begin
                    full = macc + ((~d) & MASK) + 1;
                    ss   = sgn(macc) - sgn(d);
                end
                e_cout = (full >> W) & 1;
                e_ovfl = (ss > SMAX || ss < SMIN) ? 1 : 0;
                e_acc  = full & MASK;
`ifdef ACCUM_ADDSUB_SAT_EN
                if (e_ovfl == 1) e_acc = (ss > 0) ? SMAX : (SMIN & MASK);
`endif
                if (e_ovfl == 1) msticky = 1;
            end
            2: e_acc = d;
            default: begin
                e_acc   = 0;
                msticky = 0;
            end
        endcase
        macc = e_acc;
    endtask

    task automatic send(input int op, input int d, input int hold);
        int n;
        in_valid = 1'b1;
        in_op    = op[1:0];
        in_data  = d[W-1:0];
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("handshake_wait", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model(op, d);
        chk("exec_valid", {31'd0, out_valid}, 0);
        chk("exec_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        chk("resp_valid", {31'd0, out_valid}, 1);
        chk("resp_acc", {28'd0, out_acc}, e_acc);
        chk("resp_cout", {31'd0, out_cout}, e_cout);
        chk("resp_ovfl", {31'd0, out_ovfl}, e_ovfl);
        chk("resp_sticky", {31'd0, sticky_ovfl}, msticky);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_acc", {28'd0, out_acc}, e_acc);
            chk("hold_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_valid", {31'd0, out_valid}, 0);
        chk("idle_in_ready", {31'd0, in_ready}, 1);
    endtask

    initial begin
        // reset held two cycles
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_acc", {28'd0, out_acc}, 0);
        chk("rst_sticky", {31'd0, sticky_ovfl}, 0);
        chk("rst_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        send(2, 4'b0101, 0);
        send(0, 4'b0011, 0);
`ifdef ACCUM_ADDSUB_SAT_EN
        chk("ovf_add_lit", {28'd0, out_acc}, 4'b0111);
`else
        chk("ovf_add_lit", {28'd0, out_acc}, 4'b1000);
`endif
        chk("ovf_sticky_lit", {31'd0, sticky_ovfl}, 1);

        send(3, 0, 0);
        chk("clear_sticky_lit", {31'd0, sticky_ovfl}, 0);

        send(2, 4'b0011, 0);
        send(1, 4'b0101, 0);
        chk("sub_lit", {28'd0, out_acc}, 4'b1110);
        send(2, 4'b0001, 0);
        send(0, 4'b1111, 3);
        chk("add_wrap_lit", {28'd0, out_acc}, 4'b0000);
        chk("add_wrap_cout", {31'd0, out_cout}, 1);

        // reset during EXEC discards the pending ADD
        send(2, 4'b0100, 0);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 4'b0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        macc = 0;
        msticky = 0;
        chk("rst_exec_valid", {31'd0, out_valid}, 0);
        chk("rst_exec_acc", {28'd0, out_acc}, 0);
        @(posedge clk); #1;
        chk("rst_exec_valid2", {31'd0, out_valid}, 0);
        chk("rst_exec_ready", {31'd0, in_ready}, 1);

        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(3, 0)) & ((i % 7 == 6) ? 3 : 1)
                 | ((i % 5 == 4) ? 2 : 0),
                 int'($urandom_range(MASK, 0)),
                 int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
